// File: rtl/uart_rx_param_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Holds the parity-mode and FSM enums plus the parameter-legality check.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    LOAD
  } rx_state_t;

  // Raw pin encoding 11 is folded onto PAR_NONE.
  function automatic parity_mode_t decode_parity(input logic [1:0] raw);
    parity_mode_t m;
    case (raw)
      2'b01:   m = PAR_EVEN;
      2'b10:   m = PAR_ODD;
      default: m = PAR_NONE;
    endcase
    return m;
  endfunction

  function automatic bit params_legal(input int data_bits, input int clks_per_bit,
                                      input int stop_bits, input int fifo_depth);
    return (data_bits >= 5) && (data_bits <= 9) &&
           (clks_per_bit >= 4) && (clks_per_bit <= 65535) && (clks_per_bit % 2 == 0) &&
           ((stop_bits == 1) || (stop_bits == 2)) &&
           (fifo_depth >= 2) && (fifo_depth <= 64) &&
           ((fifo_depth & (fifo_depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Host-side read/status bundle of the UART receiver.
// The host drives parity_mode and data_read; the receiver drives everything else.
interface uart_rx_param_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic [1:0]                        parity_mode;
  logic                              data_read;
  logic [DATA_BITS-1:0]              rx_data;
  logic                              data_ready;
  logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count;
  logic                              framing_error;
  logic                              parity_error;
  logic                              overrun_error;

  modport master (
    output parity_mode, data_read,
    input  rx_data, data_ready, fifo_count, framing_error, parity_error, overrun_error
  );

  modport slave (
    input  parity_mode, data_read,
    output rx_data, data_ready, fifo_count, framing_error, parity_error, overrun_error
  );
endinterface

// File: rtl/uart_rx_param_fifo.sv
// Receive FIFO with wrap-bit pointers and a registered head entry.
// The head register is reloaded on every edge so rx_data never depends on rd_en combinationally.
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           rd_en,
  output logic [WIDTH-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty,
  output logic                           full
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW:0]      wr_ptr_next, rd_ptr_next;
  logic             do_push, do_pop;

  assign count = CNTW'(wr_ptr - rd_ptr);
  assign empty = (count == '0);
  assign full  = (count == CNTW'(DEPTH));

  // A push into a full FIFO is only accepted when a pop frees a slot on the same edge.
  always_comb begin
    do_pop      = rd_en && !empty;
    do_push     = wr_en && (!full || do_pop);
    wr_ptr_next = do_push ? wr_ptr + 1'b1 : wr_ptr;
    rd_ptr_next = do_pop  ? rd_ptr + 1'b1 : rd_ptr;
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Head bypasses the memory when the entry being written becomes the new head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      if (wr_ptr_next == rd_ptr_next) begin
        rd_data <= '0;
      end else if (do_push && (rd_ptr_next == wr_ptr)) begin
        rd_data <= wr_data;
      end else begin
        rd_data <= mem[rd_ptr_next[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, mid-bit sampling FSM, optional parity,
// 1 or 2 stop bits, and a receive FIFO with framing/parity/overrun status.
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  uart_rx_param_if.slave   host
);

  if (!params_legal(DATA_BITS, CLKS_PER_BIT, STOP_BITS, FIFO_DEPTH)) begin : g_param_check
    $error("uart_rx_param: illegal parameter combination");
  end

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  rx_state_t            state;
  parity_mode_t         mode;
  logic                 sync_1, rx_s, rx_prev;
  logic [CW-1:0]        clk_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_acc;
  logic                 frame_bad, par_bad;
  logic                 framing_error_q, parity_error_q, overrun_q;
  logic                 fifo_wr, fifo_empty, fifo_full;
  logic                 fall;

  assign fall = rx_prev && !rx_s;

  // A frame is written only from LOAD, and only if clean and there is (or will be) room.
  assign fifo_wr = (state == LOAD) && !frame_bad && !par_bad &&
                   (!fifo_full || host.data_read);

  rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (shift_reg),
    .rd_en   (host.data_read),
    .rd_data (host.rx_data),
    .count   (host.fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign host.data_ready    = !fifo_empty;
  assign host.framing_error = framing_error_q;
  assign host.parity_error  = parity_error_q;
  assign host.overrun_error = overrun_q;

  // Synchroniser, edge detect and the whole receive FSM share one clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1          <= 1'b1;
      rx_s            <= 1'b1;
      rx_prev         <= 1'b1;
      state           <= IDLE;
      mode            <= PAR_NONE;
      clk_cnt         <= '0;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      par_acc         <= 1'b0;
      frame_bad       <= 1'b0;
      par_bad         <= 1'b0;
      framing_error_q <= 1'b0;
      parity_error_q  <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      sync_1  <= serial_in;
      rx_s    <= sync_1;
      rx_prev <= rx_s;

      if (host.data_read && !fifo_empty) begin
        overrun_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (fall) begin
            state           <= START;
            mode            <= decode_parity(host.parity_mode);
            framing_error_q <= 1'b0;
            parity_error_q  <= 1'b0;
            frame_bad       <= 1'b0;
            par_bad         <= 1'b0;
            par_acc         <= 1'b0;
          end
        end

        START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        DATA: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt   <= '0;
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            par_acc   <= par_acc ^ rx_s;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (mode == PAR_NONE) ? STOP : PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        PARITY: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt <= '0;
            par_bad <= (mode == PAR_EVEN) ? (par_acc ^ rx_s) : !(par_acc ^ rx_s);
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        STOP: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              frame_bad <= 1'b1;
            end
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= LOAD;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        LOAD: begin
          state <= IDLE;
          if (frame_bad) begin
            framing_error_q <= 1'b1;
          end else if (par_bad) begin
            parity_error_q <= 1'b1;
          end else if (fifo_full && !host.data_read) begin
            overrun_q <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: one default instance (1 stop bit) and one with two stop bits.
module tb_uart_rx_param;

  localparam int CPB = 10;

  logic clk;
  logic rst;
  logic serial_a, serial_b;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   start_cyc = 0;
  int   rise_cyc  = -1;
  logic dr_prev   = 1'b0;

  uart_rx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifa ();
  uart_rx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifb ();

  uart_rx_param #(
    .DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .serial_in(serial_a), .host(ifa)
  );

  uart_rx_param #(
    .DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut2 (
    .clk(clk), .rst(rst), .serial_in(serial_b), .host(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Remember the cycle number in which data_ready on the default instance last rose.
  always @(negedge clk) begin
    if (ifa.data_ready && !dr_prev) rise_cyc = cyc;
    dr_prev = ifa.data_ready;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input int which, input logic b);
    if (which == 0) serial_a = b;
    else            serial_b = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int which);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    drive_bit(which, 1'b0);
  endtask

  task automatic drive_data(input int which, input logic [7:0] data);
    for (int i = 0; i < 8; i++) drive_bit(which, data[i]);
  endtask

  task automatic finish_frame(input int which, input logic [7:0] data, input bit par_en,
                              input bit par_bit, input int nstop, input bit last_stop);
    drive_data(which, data);
    if (par_en) drive_bit(which, par_bit);
    for (int s = 0; s < nstop; s++) drive_bit(which, (s == nstop - 1) ? last_stop : 1'b1);
    drive_bit(which, 1'b1);
  endtask

  task automatic send_frame(input int which, input logic [7:0] data, input bit par_en,
                            input bit par_bit, input int nstop, input bit last_stop);
    start_frame(which);
    finish_frame(which, data, par_en, par_bit, nstop, last_stop);
  endtask

  task automatic do_pop(input int which);
    @(posedge clk);
    #1;
    if (which == 0) ifa.data_read = 1'b1;
    else            ifb.data_read = 1'b1;
    @(posedge clk);
    #1;
    ifa.data_read = 1'b0;
    ifb.data_read = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    serial_a = 1'b1;
    serial_b = 1'b1;
    ifa.parity_mode = 2'b00;
    ifa.data_read   = 1'b0;
    ifb.parity_mode = 2'b00;
    ifb.data_read   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] reset values");
    check("rst_data_ready", 32'(ifa.data_ready), 32'd0);
    check("rst_rx_data", 32'(ifa.rx_data), 32'd0);
    check("rst_fifo_count", 32'(ifa.fifo_count), 32'd0);
    check("rst_framing", 32'(ifa.framing_error), 32'd0);
    check("rst_parity", 32'(ifa.parity_error), 32'd0);
    check("rst_overrun", 32'(ifa.overrun_error), 32'd0);

    $display("[TB] 3-cycle glitch");
    @(posedge clk);
    #1 serial_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 serial_a = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("glitch_count", 32'(ifa.fifo_count), 32'd0);
    check("glitch_ready", 32'(ifa.data_ready), 32'd0);
    check("glitch_framing", 32'(ifa.framing_error), 32'd0);
    check("glitch_parity", 32'(ifa.parity_error), 32'd0);

    $display("[TB] frame 0xA5, no parity");
    rise_cyc = -1;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 1'b1);
    check("a5_ready_latency", 32'(rise_cyc - start_cyc), 32'd99);
    check("a5_rx_data", 32'(ifa.rx_data), 32'hA5);
    check("a5_count", 32'(ifa.fifo_count), 32'd1);
    check("a5_framing", 32'(ifa.framing_error), 32'd0);
    check("a5_parity", 32'(ifa.parity_error), 32'd0);
    check("a5_overrun", 32'(ifa.overrun_error), 32'd0);
    do_pop(0);
    check("a5_pop_count", 32'(ifa.fifo_count), 32'd0);
    check("a5_pop_ready", 32'(ifa.data_ready), 32'd0);
    check("a5_pop_rx_data", 32'(ifa.rx_data), 32'd0);

    $display("[TB] even parity");
    ifa.parity_mode = 2'b01;
    send_frame(0, 8'h03, 1'b1, 1'b1, 1, 1'b1);
    check("par_bad_flag", 32'(ifa.parity_error), 32'd1);
    check("par_bad_count", 32'(ifa.fifo_count), 32'd0);
    check("par_bad_framing", 32'(ifa.framing_error), 32'd0);
    start_frame(0);
    check("par_clear_at_start", 32'(ifa.parity_error), 32'd0);
    finish_frame(0, 8'h03, 1'b1, 1'b0, 1, 1'b1);
    check("par_good_flag", 32'(ifa.parity_error), 32'd0);
    check("par_good_rx_data", 32'(ifa.rx_data), 32'h03);
    check("par_good_count", 32'(ifa.fifo_count), 32'd1);
    do_pop(0);
    ifa.parity_mode = 2'b00;

    $display("[TB] overrun");
    for (int v = 1; v <= 5; v++) send_frame(0, 8'(v * 8'h11), 1'b0, 1'b0, 1, 1'b1);
    check("ovr_flag", 32'(ifa.overrun_error), 32'd1);
    check("ovr_count", 32'(ifa.fifo_count), 32'd4);
    check("ovr_rx_data", 32'(ifa.rx_data), 32'h11);
    check("ovr_framing", 32'(ifa.framing_error), 32'd0);
    do_pop(0);
    check("ovr_clear", 32'(ifa.overrun_error), 32'd0);
    check("ovr_pop_rx_data", 32'(ifa.rx_data), 32'h22);
    check("ovr_pop_count", 32'(ifa.fifo_count), 32'd3);
    send_frame(0, 8'h66, 1'b0, 1'b0, 1, 1'b1);
    check("fill_count", 32'(ifa.fifo_count), 32'd4);
    check("fill_overrun", 32'(ifa.overrun_error), 32'd0);

    $display("[TB] full FIFO with pop during LOAD");
    start_frame(0);
    drive_data(0, 8'h77);
    serial_a = 1'b1;
    repeat (8) @(posedge clk);
    #1 ifa.data_read = 1'b1;
    @(posedge clk);
    #1 ifa.data_read = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("loadpop_overrun", 32'(ifa.overrun_error), 32'd0);
    check("loadpop_count", 32'(ifa.fifo_count), 32'd4);
    check("loadpop_rx_data", 32'(ifa.rx_data), 32'h33);

    $display("[TB] two stop bits");
    send_frame(1, 8'h81, 1'b0, 1'b0, 2, 1'b1);
    check("sb2_good_count", 32'(ifb.fifo_count), 32'd1);
    check("sb2_good_rx_data", 32'(ifb.rx_data), 32'h81);
    check("sb2_good_framing", 32'(ifb.framing_error), 32'd0);
    send_frame(1, 8'h3C, 1'b0, 1'b0, 2, 1'b0);
    check("sb2_bad_framing", 32'(ifb.framing_error), 32'd1);
    check("sb2_bad_count", 32'(ifb.fifo_count), 32'd1);
    check("sb2_bad_rx_data", 32'(ifb.rx_data), 32'h81);

    $display("[TB] reset during DATA");
    start_frame(0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    serial_a = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_count", 32'(ifa.fifo_count), 32'd0);
    check("mid_rst_ready", 32'(ifa.data_ready), 32'd0);
    check("mid_rst_rx_data", 32'(ifa.rx_data), 32'd0);
    check("mid_rst_overrun", 32'(ifa.overrun_error), 32'd0);
    check("mid_rst_b_framing", 32'(ifb.framing_error), 32'd0);
    check("mid_rst_b_count", 32'(ifb.fifo_count), 32'd0);
    repeat (30) @(posedge clk);
    #1;
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1, 1'b1);
    check("post_rst_rx_data", 32'(ifa.rx_data), 32'h5A);
    check("post_rst_count", 32'(ifa.fifo_count), 32'd1);
    check("post_rst_framing", 32'(ifa.framing_error), 32'd0);
    check("post_rst_parity", 32'(ifa.parity_error), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receive block: the next-generation successor of the fixed 8-bit, 10-clocks-per-bit receiver. It adds configurable data width, bit period, stop-bit count and a runtime parity mode. Received frames go into a configurable-depth receive FIFO instead of a single-entry buffer, with framing, parity and overrun reporting. It sits between the serial input pin and the host-side read interface.

## Interface
Parameters:
- DATA_BITS, 8, payload bits per frame, legal 5..9
- CLKS_PER_BIT, 10, clk cycles per serial bit, legal 4..65535, must be even
- STOP_BITS, 1, stop bits checked per frame, legal 1 or 2
- FIFO_DEPTH, 4, receive FIFO entries, power of two, legal 2..64

Ports:
- clk  in  1  system clock; every flop is rising-edge
- rst  in  1  reset, synchronous, active-high
- serial_in  in  1  asynchronous serial line, idle high
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none; sampled only in IDLE
- data_read  in  1  pop one FIFO entry; ignored when FIFO empty
- rx_data  out  DATA_BITS  FIFO head entry; 0 when empty
- data_ready  out  1  FIFO not empty
- fifo_count  out  $clog2(FIFO_DEPTH+1)  entries held
- framing_error  out  1  last completed frame had a low stop bit
- parity_error  out  1  last completed frame failed parity
- overrun_error  out  1  sticky; a good frame was dropped because the FIFO was full

## Operation
- serial_in passes through a 2-flop synchroniser, giving rx_s. Falling-edge detection on rx_s uses a third flop.
- FSM states: IDLE, START, DATA, PARITY, STOP, LOAD.
- IDLE: on rx_s falling edge → START. Bit counter is cleared. Mode is latched from parity_mode. framing_error and parity_error are cleared.
- START: wait CLKS_PER_BIT/2 cycles to reach mid-bit, then sample. rx_s=1 → false start, return to IDLE with no flag set. rx_s=0 → DATA.
- DATA: sample every CLKS_PER_BIT cycles. Bits are LSB first into the shift register. After DATA_BITS samples, go to PARITY if mode is even or odd, otherwise go to STOP.
- PARITY: one sample. Even parity: XOR of data and parity bit must be 0. Odd parity: it must be 1.
- STOP: take STOP_BITS samples, CLKS_PER_BIT apart. Any sample that is 0 marks a framing fault.
- LOAD: single cycle, then IDLE.
  - framing fault → framing_error=1, frame discarded.
  - else parity fault → parity_error=1, frame discarded.
  - else if the FIFO is full and data_read is not asserted → frame dropped, overrun_error=1.
  - else → write the frame.
- overrun_error clears on the first cycle data_read=1 with the FIFO non-empty.
- FIFO: simultaneous write and pop is legal at any fill level, including full. fifo_count stays unchanged. rx_data shows the next entry.
- Back-to-back frames: a falling edge seen in the cycle after LOAD must be caught, so IDLE is entered immediately.

## Timing
- Reset values: FSM=IDLE, FIFO empty, rx_data=0, data_ready=0, fifo_count=0, all error flags 0, synchroniser flops=1.
- Reset asserted mid-frame discards the partial frame and all FIFO contents on the next edge.
- Take T0 as the cycle the falling edge is seen on rx_s. T0 is 2 cycles after the pin edge.
  - Start sample: T0+CLKS_PER_BIT/2.
  - Data bit i sample: T0+CLKS_PER_BIT/2+(i+1)·CLKS_PER_BIT.
- LOAD occurs the cycle after the final stop sample. data_ready, fifo_count and the error flags update on the edge ending LOAD.
- Pop: the data_read edge updates rx_data, fifo_count and data_ready in the next cycle. rx_data is a registered FIFO head with no combinational path from data_read.
- Error flags hold until the next start edge, except overrun_error, which holds until a pop.

## Structure
- Package uart_rx_pkg:
  - parity_mode_t enum (PAR_NONE, PAR_EVEN, PAR_ODD)
  - rx_state_t enum
  - parameter-legality checking function
- Sub-module rx_fifo, parametrised by WIDTH and DEPTH:
  - pointers with wrap bit
  - count output
  - registered head
- The top level holds the synchroniser, edge detect, bit-period counter, bit counter, shift register and FSM.

## Test plan
- Defaults, mode 00, send 0xA5 with 1 stop bit → data_ready rises 1 cycle after LOAD; rx_data=0xA5; fifo_count=1; no errors.
- Low glitch of 3 cycles on serial_in → START aborts at the mid-bit sample; no flags; fifo_count=0.
- Mode 01, data 0x03, parity bit 1 → parity_error=1; FIFO stays empty. Next frame 0x03 with parity 0 → parity_error clears at its start edge; rx_data=0x03.
- STOP_BITS=2, second stop bit 0 → framing_error=1; frame discarded.
- FIFO_DEPTH=4, five frames 0x11..0x55 with no reads → overrun_error=1; fifo_count=4; rx_data=0x11. One data_read → overrun_error=0; rx_data=0x22.
- FIFO full with data_read=1 in the LOAD cycle → no overrun; fifo_count stays 4. Separately, rst pulse during DATA → all outputs at reset values; the next clean frame 0x5A is received correctly.
